// File: rtl/seg_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus, with stability filtering.
// Optional SEG_DECODER_ERR_EN enables unrecognised-pattern reporting on errOut/errCntOut.
module seg_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                       clkIn,
  input  logic                       rstIn,
  input  logic [6:0]                 segIn,
  input  logic [DIGITS-1:0]          anodeIn,
  output logic [3:0]                 digitOut,
  output logic [$clog2(DIGITS)-1:0]  idxOut,
  output logic                       validOut,
  output logic                       errOut,
  output logic [7:0]                 errCntOut,
  output logic [4*DIGITS-1:0]        digitsOut,
  output logic [DIGITS-1:0]          blankOut
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int W_W   = DIGITS + 7;

  logic [6:0]        seg_s1, seg_s2;
  logic [DIGITS-1:0] anode_s1, anode_s2;
  logic [W_W-1:0]    word, word_prev;
  logic [7:0]        run_cnt;

  logic              accept;
  logic              single_low;
  logic [3:0]        low_cnt;
  logic [IDX_W-1:0]  pos;
  logic [3:0]        value;
  logic              mapped;
  logic              blank;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      seg_s1   <= 7'h7F;
      seg_s2   <= 7'h7F;
      anode_s1 <= '1;
      anode_s2 <= '1;
    end else begin
      seg_s1   <= segIn;
      seg_s2   <= seg_s1;
      anode_s1 <= anodeIn;
      anode_s2 <= anode_s1;
    end
  end

  assign word = {anode_s2, seg_s2};

  // Acceptance fires on the edge where the counter steps to STABLE_CYCLES, so a held pattern is taken once.
  assign accept = (word == word_prev) && (run_cnt == 8'(STABLE_CYCLES - 1));

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      word_prev <= {{DIGITS{1'b1}}, 7'h7F};
      run_cnt   <= '0;
    end else begin
      word_prev <= word;
      if (word != word_prev)
        run_cnt <= 8'd1;
      else if (run_cnt != 8'(STABLE_CYCLES))
        run_cnt <= run_cnt + 8'd1;
    end
  end

  always_comb begin
    low_cnt = '0;
    pos     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!anode_s2[i]) begin
        low_cnt = low_cnt + 4'd1;
        pos     = IDX_W'(i);
      end
    end
  end

  assign single_low = (low_cnt == 4'd1);

  always_comb begin
    value  = '0;
    mapped = 1'b1;
    case (seg_s2)
      7'h40: value = 4'h0;
      7'h79: value = 4'h1;
      7'h24: value = 4'h2;
      7'h30: value = 4'h3;
      7'h19: value = 4'h4;
      7'h12: value = 4'h5;
      7'h02: value = 4'h6;
      7'h78: value = 4'h7;
      7'h00: value = 4'h8;
      7'h10: value = 4'h9;
      7'h08: value = 4'hA;
      7'h03: value = 4'hB;
      7'h46: value = 4'hC;
      7'h21: value = 4'hD;
      7'h06: value = 4'hE;
      7'h0E: value = 4'hF;
      default: mapped = 1'b0;
    endcase
  end

  assign blank = (seg_s2 == 7'h7F);

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      digitOut  <= '0;
      idxOut    <= '0;
      validOut  <= 1'b0;
      digitsOut <= '0;
      blankOut  <= '1;
    end else begin
      validOut <= 1'b0;
      if (accept && single_low) begin
        if (mapped) begin
          digitsOut[4*pos +: 4] <= value;
          blankOut[pos]         <= 1'b0;
          digitOut              <= value;
          idxOut                <= pos;
          validOut              <= 1'b1;
        end else if (blank) begin
          blankOut[pos] <= 1'b1;
        end
      end
    end
  end

`ifdef SEG_DECODER_ERR_EN
  logic err_hit;
  assign err_hit = accept && single_low && !mapped && !blank;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      errOut    <= 1'b0;
      errCntOut <= '0;
    end else begin
      errOut <= err_hit;
      if (err_hit && errCntOut != 8'hFF)
        errCntOut <= errCntOut + 8'd1;
    end
  end
`else
  assign errOut    = 1'b0;
  assign errCntOut = '0;
`endif

endmodule

// File: tb/tb_seg_decoder.sv
// Directed self-checking bench for seg_decoder (DIGITS=4, STABLE_CYCLES=4).
module tb_seg_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic [3:0]  digit;
  logic [1:0]  idx;
  logic        valid;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] digits;
  logic [3:0]  blank;

  int tests  = 0;
  int failed = 0;
  int vp, ep, vfirst;

  seg_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clkIn     (clk),
    .rstIn     (rst_n),
    .segIn     (seg),
    .anodeIn   (anode),
    .digitOut  (digit),
    .idxOut    (idx),
    .validOut  (valid),
    .errOut    (err),
    .errCntOut (err_cnt),
    .digitsOut (digits),
    .blankOut  (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a pattern just after a falling edge, then sample n falling edges.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    anode = a;
    seg   = s;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (valid) begin
        vp++;
        if (vfirst == 0) vfirst = i;
      end
      if (err) ep++;
    end
  endtask

  task automatic clear_counts();
    vp = 0; ep = 0; vfirst = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_digit"},  32'(digit),   32'h0);
    check({tag, "_idx"},    32'(idx),     32'h0);
    check({tag, "_valid"},  32'(valid),   32'h0);
    check({tag, "_err"},    32'(err),     32'h0);
    check({tag, "_errcnt"}, 32'(err_cnt), 32'h0);
    check({tag, "_digits"}, 32'(digits),  32'h0);
    check({tag, "_blank"},  32'(blank),   32'hF);
  endtask

  initial begin
    logic [6:0] cyc_seg [4];
    cyc_seg[0] = 7'h30; cyc_seg[1] = 7'h08; cyc_seg[2] = 7'h46; cyc_seg[3] = 7'h0E;

    rst_n = 1'b0;
    seg   = 7'h7F;
    anode = 4'hF;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Idle all-high anode must never be accepted as a digit.
    clear_counts();
    hold(4'hF, 7'h7F, 10);
    check("idle_valid", 32'(vp), 32'd0);

    // Single digit, exact latency and once-only acceptance.
    clear_counts();
    hold(4'b1110, 7'h24, 20);
    check("t1_latency", 32'(vfirst), 32'd6);
    check("t1_pulses",  32'(vp),     32'd1);
    check("t1_digit",   32'(digit),  32'h2);
    check("t1_idx",     32'(idx),    32'h0);
    check("t1_digits",  32'(digits), 32'h0002);
    check("t1_blank",   32'(blank),  32'b1110);

    // Scan all positions with inter-digit gaps.
    clear_counts();
    for (int p = 0; p < 4; p++) begin
      hold(~(4'b1 << p), cyc_seg[p], 10);
      hold(4'hF, cyc_seg[p], 3);
    end
    check("t2_pulses", 32'(vp),     32'd4);
    check("t2_digits", 32'(digits), 32'hFCA3);
    check("t2_digit",  32'(digit),  32'hF);
    check("t2_idx",    32'(idx),    32'h3);
    check("t2_blank",  32'(blank),  32'h0);

    // Anode-only changes restart the run.
    clear_counts();
    for (int t = 0; t < 8; t++)
      hold((t % 2) ? 4'b1101 : 4'b1011, 7'h40, 2);
    check("t3_glitch_pulses", 32'(vp), 32'd0);
    hold(4'b1011, 7'h40, 10);
    check("t3_pulses", 32'(vp),     32'd1);
    check("t3_idx",    32'(idx),    32'h2);
    check("t3_digit",  32'(digit),  32'h0);
    check("t3_digits", 32'(digits), 32'hF0A3);

    // Unrecognised pattern and error-count saturation.
    clear_counts();
    hold(4'b0111, 7'h55, 10);
`ifdef SEG_DECODER_ERR_EN
    check("t4_err_pulse", 32'(ep),      32'd1);
    check("t4_errcnt1",   32'(err_cnt), 32'd1);
`else
    check("t4_err_pulse", 32'(ep),      32'd0);
    check("t4_errcnt1",   32'(err_cnt), 32'd0);
`endif
    check("t4_valid",  32'(vp),     32'd0);
    check("t4_digits", 32'(digits), 32'hF0A3);
    for (int r = 0; r < 299; r++) begin
      hold(4'hF, 7'h55, 2);
      hold(4'b0111, 7'h55, 7);
    end
`ifdef SEG_DECODER_ERR_EN
    check("t4_err_total", 32'(ep),      32'd300);
    check("t4_errcnt",    32'(err_cnt), 32'd255);
`else
    check("t4_err_total", 32'(ep),      32'd0);
    check("t4_errcnt",    32'(err_cnt), 32'd0);
`endif
    check("t4_blank", 32'(blank), 32'h0);

    // Blank pattern on an accepted position.
    clear_counts();
    hold(4'b1101, 7'h10, 10);
    check("t5_pulse",  32'(vp),     32'd1);
    check("t5_digits", 32'(digits), 32'hF093);
    clear_counts();
    hold(4'b1101, 7'h7F, 10);
    check("t5_blank_valid", 32'(vp),          32'd0);
    check("t5_blank_err",   32'(ep),          32'd0);
    check("t5_blank1",      32'(blank),       32'b0010);
    check("t5_pos1",        32'(digits[7:4]), 32'h9);

    // Reset asserted while the run counter sits one short of acceptance.
    clear_counts();
    hold(4'b1110, 7'h24, 5);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_prereset_valid", 32'(vp), 32'd0);
    check_reset_values("t6");
    rst_n = 1'b1;
    clear_counts();
    hold(4'b1110, 7'h24, 12);
    check("t6_latency", 32'(vfirst), 32'd6);
    check("t6_pulses",  32'(vp),     32'd1);
    check("t6_digits",  32'(digits), 32'h0002);
    check("t6_blank",   32'(blank),  32'b1110);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
